// File: rtl/kat_iic_arbiter.sv
// -----------------------------------------------------------------------------
// kat_iic_arbiter
//
// Shares one downstream IIC op FIFO between NUM_REQ requesters. A requester
// wins the bus by presenting an op word with the start bit set while the
// arbiter is idle; round-robin order begins at the requester after the last
// owner. The owner then streams op words straight into the FIFO until it sends
// one with the stop bit set. The arbiter then holds the bus in a drain phase
// until the downstream FIFO reports it has emptied (xfer_done). Read bytes
// coming back from the RX path are steered to the current owner only.
//
// Optional feature (compile-time macro):
//   KAT_IIC_ARB_TIMEOUT_EN - builds an owner-idle watchdog. After
//   TIMEOUT_CYCLES consecutive OWN cycles with no accepted op, the bus is
//   forced into the drain phase and timeout_err pulses for one cycle. When
//   the macro is undefined no counter exists and timeout_err is tied low.
//
// Ports:
//   OPB_Clk          in   sole clock, rising edge
//   OPB_Rst          in   asynchronous active-high reset
//   req_valid        in   [NUM_REQ]     per-requester op word valid
//   req_op           in   [11*NUM_REQ]  op words, slice i = [11i+10:11i]
//                                      bit10 stop, bit9 start, bit8 rnw,
//                                      bits7:0 write data
//   req_ready        out  [NUM_REQ]     op word of requester i accepted when
//                                      req_valid[i] & req_ready[i]
//   op_fifo_wr_en    out  write strobe to the downstream op FIFO
//   op_fifo_wr_data  out  [11]          op word to the downstream op FIFO
//   op_fifo_full     in   downstream op FIFO full
//   xfer_done        in   one-cycle pulse when the downstream FIFO drains
//   rx_valid         in   read byte valid from the RX path
//   rx_data          in   [8]           read byte from the RX path
//   rx_valid_o       out  [NUM_REQ]     read byte valid, owner only
//   rx_data_o        out  [8]           read byte routed to the owner
//   grant            out  [NUM_REQ]     one-hot owner, zero when idle
//   busy             out  high while a requester owns or drains the bus
//   timeout_err      out  one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module kat_iic_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   OPB_Clk,
  input  logic                   OPB_Rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [11*NUM_REQ-1:0]  req_op,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   op_fifo_wr_en,
  output logic [10:0]            op_fifo_wr_data,
  input  logic                   op_fifo_full,
  input  logic                   xfer_done,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic [NUM_REQ-1:0]     rx_valid_o,
  output logic [7:0]             rx_data_o,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One extra bit so last_owner + offset never overflows before the wrap.
  localparam int CAND_W = IDX_W + 1;
  localparam logic [CAND_W-1:0] NUM_REQ_C      = CAND_W'(NUM_REQ);
  // Reset points last_owner at the top requester so requester 0 goes first.
  localparam logic [IDX_W-1:0]  LAST_OWNER_RST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    last_owner_q, last_owner_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;

  logic [10:0]         op_arr_s [NUM_REQ];
  logic [NUM_REQ-1:0]  elig_s;
  logic [10:0]         owner_op_s;
  logic                owner_valid_s;
  logic                accept_s;
  logic                to_hit_s;

  logic                pick_found_s;
  logic                pick_hit_s;
  logic [IDX_W-1:0]    pick_idx_s;
  logic [CAND_W-1:0]   cand_sum_s;
  logic [CAND_W-1:0]   cand_s;

  // Unpack the flat op bus and flag requesters whose head op carries start.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      op_arr_s[i] = req_op[11*i +: 11];
      elig_s[i]   = req_valid[i] & req_op[11*i + 9];
    end
  end

  assign owner_op_s    = op_arr_s[owner_q];
  assign owner_valid_s = req_valid[owner_q];
  assign accept_s      = (state_q == ST_OWN) && owner_valid_s && !op_fifo_full;

  // Round-robin search: walk offsets 1..NUM_REQ from last_owner, wrapping
  // modulo NUM_REQ, and keep the first eligible requester found.
  always_comb begin
    pick_found_s = 1'b0;
    pick_hit_s   = 1'b0;
    pick_idx_s   = '0;
    cand_sum_s   = '0;
    cand_s       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_sum_s   = {1'b0, last_owner_q} + CAND_W'(k);
      cand_s       = (cand_sum_s >= NUM_REQ_C) ? (cand_sum_s - NUM_REQ_C) : cand_sum_s;
      pick_hit_s   = !pick_found_s && elig_s[cand_s[IDX_W-1:0]];
      pick_idx_s   = pick_hit_s ? cand_s[IDX_W-1:0] : pick_idx_s;
      pick_found_s = pick_found_s | pick_hit_s;
    end
  end

`ifdef KAT_IIC_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_err_q, timeout_err_d;

  // Owner-idle watchdog: cleared outside OWN (so entry to OWN starts at zero)
  // and on every accepted op, counts every OWN cycle without an accept.
  always_comb begin
    to_cnt_d      = to_cnt_q;
    to_hit_s      = 1'b0;
    timeout_err_d = 1'b0;
    if (state_q == ST_OWN) begin
      if (accept_s) begin
        to_cnt_d = '0;
      end else begin
        to_cnt_d      = to_cnt_q + TO_W'(1);
        to_hit_s      = (to_cnt_d == TO_LIMIT);
        timeout_err_d = to_hit_s;
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  // Watchdog counter and the registered forced-release pulse.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign to_hit_s    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register together with the ownership bookkeeping flops.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_owner_q <= LAST_OWNER_RST;
      grant_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      grant_q      <= grant_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, leave OWN on an accepted stop op
  // (or a watchdog hit), leave DRAIN only on xfer_done.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    grant_d      = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_d             = ST_OWN;
          owner_d             = pick_idx_s;
          grant_d             = '0;
          grant_d[pick_idx_s] = 1'b1;
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      ST_OWN: begin
        // A stop op being accepted takes the same path whether or not
        // start is also set in that word.
        if (accept_s && owner_op_s[10]) begin
          state_d = ST_DRAIN;
        end else if (to_hit_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_OWN;
        end
      end
      ST_DRAIN: begin
        if (xfer_done) begin
          state_d      = ST_IDLE;
          grant_d      = '0;
          last_owner_d = owner_q;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Output decode: the FIFO handshake passes straight through for the owner
  // in OWN; RX bytes reach the owner in OWN and DRAIN; everything is zero in
  // IDLE so an asynchronous reset clears the outputs immediately.
  always_comb begin
    req_ready       = '0;
    op_fifo_wr_en   = 1'b0;
    op_fifo_wr_data = 11'd0;
    rx_valid_o      = '0;
    rx_data_o       = 8'd0;
    case (state_q)
      ST_IDLE: begin
        req_ready = '0;
      end
      ST_OWN: begin
        req_ready[owner_q]  = !op_fifo_full;
        op_fifo_wr_en       = owner_valid_s && !op_fifo_full;
        op_fifo_wr_data     = owner_op_s;
        rx_valid_o[owner_q] = rx_valid;
        rx_data_o           = rx_data;
      end
      ST_DRAIN: begin
        rx_valid_o[owner_q] = rx_valid;
        rx_data_o           = rx_data;
      end
      default: begin
        req_ready = '0;
      end
    endcase
  end

  assign grant = grant_q;
  assign busy  = (state_q == ST_OWN) || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_kat_iic_arbiter.sv
// -----------------------------------------------------------------------------
// tb_kat_iic_arbiter
//
// Directed bench for kat_iic_arbiter with NUM_REQ=4 and TIMEOUT_CYCLES=16.
// Inputs change 1 time unit after the rising edge; outputs are compared a
// further unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_kat_iic_arbiter;

  localparam int NR = 4;

  logic            OPB_Clk = 1'b0;
  logic            OPB_Rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [11*NR-1:0] req_op = '0;
  logic [NR-1:0]   req_ready;
  logic            op_fifo_wr_en;
  logic [10:0]     op_fifo_wr_data;
  logic            op_fifo_full = 1'b0;
  logic            xfer_done = 1'b0;
  logic            rx_valid = 1'b0;
  logic [7:0]      rx_data = 8'd0;
  logic [NR-1:0]   rx_valid_o;
  logic [7:0]      rx_data_o;
  logic [NR-1:0]   grant;
  logic            busy;
  logic            timeout_err;

  int checks = 0;
  int errors = 0;

  kat_iic_arbiter #(
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .OPB_Clk         (OPB_Clk),
    .OPB_Rst         (OPB_Rst),
    .req_valid       (req_valid),
    .req_op          (req_op),
    .req_ready       (req_ready),
    .op_fifo_wr_en   (op_fifo_wr_en),
    .op_fifo_wr_data (op_fifo_wr_data),
    .op_fifo_full    (op_fifo_full),
    .xfer_done       (xfer_done),
    .rx_valid        (rx_valid),
    .rx_data         (rx_data),
    .rx_valid_o      (rx_valid_o),
    .rx_data_o       (rx_data_o),
    .grant           (grant),
    .busy            (busy),
    .timeout_err     (timeout_err)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  task automatic tick();
    @(posedge OPB_Clk);
    #1;
  endtask

  task automatic set_op(input int idx, input logic [10:0] op);
    req_op[11*idx +: 11] = op;
  endtask

  task automatic clear_inputs();
    req_valid    = '0;
    req_op       = '0;
    op_fifo_full = 1'b0;
    xfer_done    = 1'b0;
    rx_valid     = 1'b0;
    rx_data      = 8'd0;
  endtask

  task automatic drain_done();
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    OPB_Rst   = 1'b1;
    req_valid = 4'b1111;
    set_op(0, 11'h200); set_op(1, 11'h201); set_op(2, 11'h202); set_op(3, 11'h203);
    rx_valid  = 1'b1;
    rx_data   = 8'hAA;
    tick(); tick();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rst_grant got %b want %b", grant, 4'b0000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b want 0000", req_ready); end
    checks++; if (op_fifo_wr_en !== 1'b0 || op_fifo_wr_data !== 11'h000) begin errors++; $display("FAIL rst_wr got en=%b data=%h want en=0 data=000", op_fifo_wr_en, op_fifo_wr_data); end
    checks++; if (rx_valid_o !== 4'b0000 || rx_data_o !== 8'h00) begin errors++; $display("FAIL rst_rx got %b/%h want 0000/00", rx_valid_o, rx_data_o); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout got %b want 0", timeout_err); end
    clear_inputs();
    OPB_Rst = 1'b0;
    tick();
  endtask

  // req0: start|A0, 10, stop|55 ; last_owner 3 -> req0 first
  task automatic test_basic();
    req_valid = 4'b0001;
    set_op(0, 11'h2A0);
    #1;
    checks++; if (req_ready !== 4'b0000 || grant !== 4'b0000) begin errors++; $display("FAIL basic_idle got ready=%b grant=%b want 0000/0000", req_ready, grant); end
    tick();
    checks++; if (grant !== 4'b0001 || busy !== 1'b1) begin errors++; $display("FAIL basic_grant got %b busy=%b want 0001 busy=1", grant, busy); end
    checks++; if (op_fifo_wr_en !== 1'b1 || op_fifo_wr_data !== 11'h2A0 || req_ready !== 4'b0001) begin errors++; $display("FAIL basic_wr0 got en=%b data=%h ready=%b want 1/2a0/0001", op_fifo_wr_en, op_fifo_wr_data, req_ready); end
    tick();
    set_op(0, 11'h010);
    xfer_done = 1'b1;
    #1;
    checks++; if (op_fifo_wr_en !== 1'b1 || op_fifo_wr_data !== 11'h010) begin errors++; $display("FAIL basic_wr1 got en=%b data=%h want 1/010", op_fifo_wr_en, op_fifo_wr_data); end
    tick();
    xfer_done = 1'b0;
    set_op(0, 11'h455);
    #1;
    checks++; if (grant !== 4'b0001 || op_fifo_wr_en !== 1'b1 || op_fifo_wr_data !== 11'h455) begin errors++; $display("FAIL basic_wr2 got grant=%b en=%b data=%h want 0001/1/455", grant, op_fifo_wr_en, op_fifo_wr_data); end
    tick();
    req_valid = 4'b0000;
    #1;
    checks++; if (busy !== 1'b1 || req_ready !== 4'b0000 || grant !== 4'b0001) begin errors++; $display("FAIL basic_drain got busy=%b ready=%b grant=%b want 1/0000/0001", busy, req_ready, grant); end
    req_valid = 4'b0001;
    tick();
    checks++; if (op_fifo_wr_en !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL basic_drain_hold got en=%b ready=%b busy=%b want 0/0000/1", op_fifo_wr_en, req_ready, busy); end
    req_valid = 4'b0000;
    drain_done();
    checks++; if (busy !== 1'b0 || grant !== 4'b0000) begin errors++; $display("FAIL basic_idle_end got busy=%b grant=%b want 0/0000", busy, grant); end
  endtask

  task automatic test_round_robin();
    // req1 start|stop makes last_owner 1
    req_valid = 4'b0010;
    set_op(1, 11'h6C1);
    tick();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL rr_pre_grant got %b want 0010", grant); end
    tick();
    req_valid = 4'b0000;
    #1;
    checks++; if (busy !== 1'b1 || req_ready !== 4'b0000) begin errors++; $display("FAIL rr_startstop_drain got busy=%b ready=%b want 1/0000", busy, req_ready); end
    drain_done();
    req_valid = 4'b0110;
    set_op(1, 11'h2B1);
    set_op(2, 11'h2B2);
    tick();
    checks++; if (grant !== 4'b0100 || op_fifo_wr_data !== 11'h2B2) begin errors++; $display("FAIL rr_first got grant=%b data=%h want 0100/2b2", grant, op_fifo_wr_data); end
    tick();
    set_op(2, 11'h4B3);
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rr_nonowner_ready got %b want 0100", req_ready); end
    tick();
    req_valid = 4'b0010;
    #1;
    checks++; if (grant !== 4'b0100 || busy !== 1'b1 || req_ready !== 4'b0000) begin errors++; $display("FAIL rr_drain got grant=%b busy=%b ready=%b want 0100/1/0000", grant, busy, req_ready); end
    drain_done();
    checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL rr_gap got grant=%b busy=%b want 0000/0", grant, busy); end
    tick();
    checks++; if (grant !== 4'b0010 || op_fifo_wr_data !== 11'h2B1) begin errors++; $display("FAIL rr_second got grant=%b data=%h want 0010/2b1", grant, op_fifo_wr_data); end
    tick();
    set_op(1, 11'h4B4);
    tick();
    req_valid = 4'b0000;
    drain_done();
  endtask

  // last_owner 1: only req0 contends
  task automatic test_full();
    req_valid = 4'b0001;
    set_op(0, 11'h2C0);
    tick();
    op_fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (req_ready !== 4'b0000 || op_fifo_wr_en !== 1'b0) begin errors++; $display("FAIL full_stall%0d got ready=%b en=%b want 0000/0", i, req_ready, op_fifo_wr_en); end
      tick();
    end
    op_fifo_full = 1'b0;
    #1;
    checks++; if (op_fifo_wr_en !== 1'b1 || req_ready !== 4'b0001 || op_fifo_wr_data !== 11'h2C0) begin errors++; $display("FAIL full_release got en=%b ready=%b data=%h want 1/0001/2c0", op_fifo_wr_en, req_ready, op_fifo_wr_data); end
    tick();
    set_op(0, 11'h4C1);
    tick();
    req_valid = 4'b0000;
    drain_done();
  endtask

  // last_owner 0: req2 owns the read
  task automatic test_rx();
    req_valid = 4'b0100;
    set_op(2, 11'h300);
    tick();
    checks++; if (grant !== 4'b0100 || op_fifo_wr_data !== 11'h300) begin errors++; $display("FAIL rx_grant got grant=%b data=%h want 0100/300", grant, op_fifo_wr_data); end
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    #1;
    checks++; if (rx_valid_o !== 4'b0100 || rx_data_o !== 8'h5A) begin errors++; $display("FAIL rx_own got %b/%h want 0100/5a", rx_valid_o, rx_data_o); end
    rx_valid = 1'b0;
    tick();
    set_op(2, 11'h500);
    tick();
    req_valid = 4'b0000;
    rx_valid  = 1'b1;
    rx_data   = 8'h3C;
    #1;
    checks++; if (rx_valid_o !== 4'b0100 || rx_data_o !== 8'h3C || busy !== 1'b1) begin errors++; $display("FAIL rx_drain got %b/%h busy=%b want 0100/3c/1", rx_valid_o, rx_data_o, busy); end
    rx_valid = 1'b0;
    drain_done();
    rx_valid = 1'b1;
    #1;
    checks++; if (rx_valid_o !== 4'b0000 || rx_data_o !== 8'h00) begin errors++; $display("FAIL rx_idle got %b/%h want 0000/00", rx_valid_o, rx_data_o); end
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // last_owner 2: req1 without start must never win
  task automatic test_nostart_reset();
    req_valid = 4'b0010;
    set_op(1, 11'h012);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (grant !== 4'b0000 || req_ready !== 4'b0000) begin errors++; $display("FAIL nostart%0d got grant=%b ready=%b want 0000/0000", i, grant, req_ready); end
    end
    req_valid = 4'b0011;
    set_op(0, 11'h2D0);
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL nostart_other got %b want 0001", grant); end
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    #2;
    OPB_Rst = 1'b1;
    #1;
    checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL arst_state got grant=%b busy=%b want 0000/0", grant, busy); end
    checks++; if (req_ready !== 4'b0000 || op_fifo_wr_en !== 1'b0 || op_fifo_wr_data !== 11'h000) begin errors++; $display("FAIL arst_wr got ready=%b en=%b data=%h want 0000/0/000", req_ready, op_fifo_wr_en, op_fifo_wr_data); end
    checks++; if (rx_valid_o !== 4'b0000 || rx_data_o !== 8'h00) begin errors++; $display("FAIL arst_rx got %b/%h want 0000/00", rx_valid_o, rx_data_o); end
    OPB_Rst = 1'b0;
    clear_inputs();
    tick();
    // reset restored last_owner to 3, so req0 beats req3
    req_valid = 4'b1001;
    set_op(0, 11'h6E0);
    set_op(3, 11'h2E3);
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL arst_rr got %b want 0001", grant); end
    tick();
    req_valid = 4'b0000;
    drain_done();
  endtask

  // last_owner 0: req1 starts then goes quiet
  task automatic test_timeout();
    req_valid = 4'b0010;
    set_op(1, 11'h2F1);
    tick();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL to_grant got %b want 0010", grant); end
    tick();
    req_valid = 4'b0000;
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++; if (timeout_err !== 1'b0 || req_ready !== 4'b0010) begin errors++; $display("FAIL to_wait%0d got err=%b ready=%b want 0/0010", i, timeout_err, req_ready); end
    end
    tick();
`ifdef KAT_IIC_ARB_TIMEOUT_EN
    checks++; if (timeout_err !== 1'b1 || req_ready !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL to_fire got err=%b ready=%b busy=%b want 1/0000/1", timeout_err, req_ready, busy); end
    tick();
    checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_pulse got err=%b busy=%b want 0/1", timeout_err, busy); end
    drain_done();
`else
    checks++; if (timeout_err !== 1'b0 || req_ready !== 4'b0010) begin errors++; $display("FAIL to_off got err=%b ready=%b want 0/0010", timeout_err, req_ready); end
    req_valid = 4'b0010;
    set_op(1, 11'h4F1);
    tick();
    req_valid = 4'b0000;
    drain_done();
`endif
    checks++; if (busy !== 1'b0 || grant !== 4'b0000) begin errors++; $display("FAIL to_end got busy=%b grant=%b want 0/0000", busy, grant); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_full();
    test_rx();
    test_nostart_reset();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
